// File: rtl/vdf_square_loop_ctrl.sv
// vdf_square_loop_ctrl: launches the modular squarer, counts T results, captures the last one
// and streams it out as canonical WORD_LEN-bit words, least significant first.
module vdf_square_loop_ctrl #(
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = 64,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int BIT_LEN               = 17,
  parameter int WORD_LEN              = 16,
  parameter int ITER_W                = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ITER_W-1:0]               iterations,
  input  logic [BIT_LEN*NUM_ELEMENTS-1:0] x_in,
  output logic                            busy,
  output logic                            sq_start,
  output logic [BIT_LEN*NUM_ELEMENTS-1:0] sq_in,
  input  logic [BIT_LEN*NUM_ELEMENTS-1:0] sq_out,
  input  logic                            sq_valid,
  output logic [WORD_LEN-1:0]             word_out,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic                            word_last,
  output logic [BIT_LEN-WORD_LEN:0]       carry_out,
  output logic                            done
);
  localparam int TOT_W = BIT_LEN * NUM_ELEMENTS;
  localparam int IDX_W = $clog2(NUM_ELEMENTS);
  localparam int C_W   = BIT_LEN - WORD_LEN + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  // state  | meaning
  // IDLE   | waiting for start; done pulses here right after a job
  // LAUNCH | sq_start high for this one cycle
  // RUN    | counting squarer valids down to the T-th result
  // DRAIN  | presenting normalised words to the consumer
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_left_q, iter_left_d;
  logic [TOT_W-1:0]  cap_buf_q, cap_buf_d;
  logic [TOT_W-1:0]  sq_in_q, sq_in_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [WORD_LEN-1:0] word_out_q, word_out_d;
  logic [C_W-1:0]    carry_out_q, carry_out_d;
  logic busy_q, busy_d, sq_start_q, sq_start_d;
  logic word_valid_q, word_valid_d, word_last_q, word_last_d, done_q, done_d;

  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [C_W-1:0]   load_c;
  logic [BIT_LEN:0] sum;

  always_comb begin
    state_d      = state_q;
    iter_left_d  = iter_left_q;
    cap_buf_d    = cap_buf_q;
    sq_in_d      = sq_in_q;
    idx_d        = idx_q;
    c_d          = c_q;
    word_out_d   = word_out_q;
    carry_out_d  = carry_out_q;
    word_valid_d = word_valid_q;
    word_last_d  = word_last_q;
    done_d       = 1'b0;
    load         = 1'b0;
    load_idx     = '0;
    load_c       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sq_in_d     = x_in;
          iter_left_d = iterations;
          if (iterations == '0) begin
            cap_buf_d = x_in;
            state_d   = S_DRAIN;
            load      = 1'b1;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (sq_valid) begin
          if (iter_left_q == ITER_W'(1)) begin
            cap_buf_d = sq_out;
            state_d   = S_DRAIN;
            load      = 1'b1;
          end
          iter_left_d = iter_left_q - ITER_W'(1);
        end
      end
      S_DRAIN: begin
        if (word_valid_q && word_ready) begin
          if (word_last_q) begin
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
            carry_out_d  = '0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            load     = 1'b1;
            load_idx = idx_q + 1'b1;
            load_c   = c_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // word for load_idx comes from the buffer value being written this cycle (entry case)
    sum = {1'b0, cap_buf_d[int'(load_idx) * BIT_LEN +: BIT_LEN]}
        + {{(BIT_LEN + 1 - C_W){1'b0}}, load_c};
    if (load) begin
      idx_d        = load_idx;
      c_d          = sum[BIT_LEN:WORD_LEN];
      word_out_d   = sum[WORD_LEN-1:0];
      word_valid_d = 1'b1;
      word_last_d  = (load_idx == LAST_IDX);
      carry_out_d  = (load_idx == LAST_IDX) ? sum[BIT_LEN:WORD_LEN] : '0;
    end

    busy_d     = (state_d != S_IDLE);
    sq_start_d = (state_d == S_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      iter_left_q  <= '0;
      cap_buf_q    <= '0;
      sq_in_q      <= '0;
      idx_q        <= '0;
      c_q          <= '0;
      word_out_q   <= '0;
      carry_out_q  <= '0;
      busy_q       <= 1'b0;
      sq_start_q   <= 1'b0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_left_q  <= iter_left_d;
      cap_buf_q    <= cap_buf_d;
      sq_in_q      <= sq_in_d;
      idx_q        <= idx_d;
      c_q          <= c_d;
      word_out_q   <= word_out_d;
      carry_out_q  <= carry_out_d;
      busy_q       <= busy_d;
      sq_start_q   <= sq_start_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign sq_start   = sq_start_q;
  assign sq_in      = sq_in_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;
  assign carry_out  = carry_out_q;
  assign done       = done_q;

endmodule
